// File: rtl/instruction_prefetch_pkg.sv
// Shared widths, FSM encodings and the buffered entry layout for the prefetch unit.
package instruction_prefetch_pkg;
    localparam int AW = 18;
    localparam int DW = 36;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        REQ     = 2'b01,
        DISCARD = 2'b10
    } state_t;

    typedef struct packed {
        logic [0:AW-1] addr;
        logic [0:DW-1] data;
    } entry_t;
endpackage

// File: rtl/prefetch_fifo.sv
// DEPTH-entry {addr,data} buffer with head/tail pointers and occupancy count; clr beats wr and pop.
module prefetch_fifo
    import instruction_prefetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTRW  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            wr,
    input  logic            pop,
    input  logic            clr,
    input  entry_t          wdata,
    output entry_t          head,
    output logic [PTRW:0]   count
);
    localparam logic [PTRW:0] FULL = (PTRW+1)'(DEPTH);

    entry_t          mem [DEPTH];
    logic [PTRW-1:0] hd, tl;
    logic            do_wr, do_pop;

    assign do_wr  = wr && (count != FULL);
    assign do_pop = pop && (count != '0);
    assign head   = mem[hd];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hd    <= '0;
            tl    <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (en) begin
            if (clr) begin
                hd    <= '0;
                tl    <= '0;
                count <= '0;
            end else begin
                if (do_wr) begin
                    mem[tl] <= wdata;
                    tl      <= tl + 1'b1;
                end
                if (do_pop) hd <= hd + 1'b1;
                case ({do_wr, do_pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end
endmodule

// File: rtl/instruction_prefetch.sv
// Sequential instruction fetch: one outstanding memory read, buffered words popped by the IR path.
module instruction_prefetch
    import instruction_prefetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTRW  = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clken,
    output logic          memREQ,
    output logic [0:AW-1] memADDR,
    input  logic          memACK,
    input  logic [0:DW-1] memDATA,
    output logic          instVALID,
    output logic [0:DW-1] instWORD,
    output logic [0:AW-1] instPC,
    input  logic          instTAKE,
    input  logic          flush,
    input  logic [0:AW-1] flushPC
);
    localparam logic [PTRW:0] FULL = (PTRW+1)'(DEPTH);

    state_t        state;
    logic [0:AW-1] fetchPC;
    entry_t        head;
    logic [PTRW:0] count;
    logic          wr;

    assign wr        = (state == REQ) && memACK && !flush;
    assign instVALID = (count != '0);
    assign instWORD  = head.data;
    assign instPC    = head.addr;

    prefetch_fifo #(.DEPTH(DEPTH), .PTRW(PTRW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .en    (clken),
        .wr    (wr),
        .pop   (instTAKE && instVALID),
        .clr   (flush),
        .wdata ('{addr: memADDR, data: memDATA}),
        .head  (head),
        .count (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            memREQ  <= 1'b0;
            memADDR <= '0;
            fetchPC <= '0;
        end else if (clken) begin
            if (flush) fetchPC <= flushPC;
            case (state)
                IDLE: begin
                    if (count != FULL && !flush) begin
                        memREQ  <= 1'b1;
                        memADDR <= fetchPC;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (memACK) begin
                        memREQ <= 1'b0;
                        state  <= IDLE;
                        if (!flush) fetchPC <= fetchPC + 1'b1;
                    end else if (flush) begin
                        // the bus read cannot be withdrawn; wait it out and drop it
                        state <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (memACK) begin
                        memREQ <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    memREQ <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_prefetch.sv
// Randomized bench: queue-based reference model updated at each edge, monitor compares on the falling edge.
module tb_instruction_prefetch;
    logic        clk = 1'b0;
    logic        rst, clken, memREQ, memACK, instVALID, instTAKE, flush;
    logic [0:17] memADDR, instPC, flushPC;
    logic [0:35] memDATA, instWORD;

    int checks = 0, failures = 0;
    int nacks;
    bit saw0;

    always #5 clk = ~clk;

    instruction_prefetch #(.DEPTH(4), .PTRW(2)) dut (
        .clk(clk), .rst(rst), .clken(clken),
        .memREQ(memREQ), .memADDR(memADDR), .memACK(memACK), .memDATA(memDATA),
        .instVALID(instVALID), .instWORD(instWORD), .instPC(instPC), .instTAKE(instTAKE),
        .flush(flush), .flushPC(flushPC)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: buffered words as a queue, one outstanding read tracked by flags.
    logic [53:0] q[$];
    logic [17:0] m_next = '0, m_addr = '0;
    bit          m_out = 0, m_drop = 0;
    int          m_sz;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete(); m_next = '0; m_addr = '0; m_out = 0; m_drop = 0;
        end else if (clken) begin
            m_sz = q.size();
            if (flush) begin
                q.delete();
                m_next = flushPC;
                if (m_out && memACK) begin m_out = 0; m_drop = 0; end
                else if (m_out) m_drop = 1;
            end else begin
                if (instTAKE && m_sz > 0) void'(q.pop_front());
                if (m_out && memACK) begin
                    if (!m_drop) begin
                        q.push_back({m_addr, memDATA});
                        m_next = 18'(m_addr + 1);
                    end
                    m_out = 0; m_drop = 0;
                end else if (!m_out && m_sz < 4) begin
                    m_out = 1; m_addr = m_next;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("memREQ", 64'(memREQ), 64'(m_out));
            if (m_out) chk("memADDR", 64'(memADDR), 64'(m_addr));
            chk("instVALID", 64'(instVALID), 64'(q.size() != 0));
            if (instVALID && q.size() != 0) chk("head", 64'({instPC, instWORD}), 64'(q[0]));
        end
    end

    function automatic logic [35:0] rnd36();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[35:0];
    endfunction

    task automatic step(input bit tk, input bit fl, input logic [17:0] fpc, input bit ak, input logic [35:0] d);
        instTAKE = tk; flush = fl; flushPC = fpc; memACK = ak; memDATA = d;
        @(posedge clk); #1;
        instTAKE = 0; flush = 0; memACK = 0;
    endtask

    // take_mode: 0 never, 1 always, 2 random; ack arrives 'dly'+1 cycles into each request
    task automatic run(input int n, input int take_mode, input int dly, input bit xor_data);
        int  wcnt = 0;
        bit  ak, tk;
        logic [35:0] d;
        for (int i = 0; i < n; i++) begin
            ak = 0;
            if (memREQ) begin
                if (memADDR == 18'd0) saw0 = 1;
                if (wcnt == dly) begin ak = 1; wcnt = 0; end
                else wcnt++;
            end else wcnt = 0;
            tk = (take_mode == 1) || (take_mode == 2 && $urandom_range(0, 1) == 1);
            d  = xor_data ? ({18'd0, memADDR} ^ 36'o525252) : rnd36();
            if (ak) nacks++;
            step(tk, 0, 18'd0, ak, d);
        end
    endtask

    task automatic wait_req(input int maxc);
        for (int i = 0; i < maxc && !memREQ; i++) step(0, 0, 18'd0, 0, 36'd0);
        chk("wait_req", 64'(memREQ), 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && memREQ; i++) step(0, 0, 18'd0, 1, rnd36());
    endtask

    initial begin
        rst = 0; clken = 1; memACK = 0; memDATA = '0; instTAKE = 0; flush = 0; flushPC = '0;
        #2 rst = 1;
        @(posedge clk); #1;
        chk("rst memREQ", 64'(memREQ), 64'd0);
        chk("rst memADDR", 64'(memADDR), 64'd0);
        chk("rst instVALID", 64'(instVALID), 64'd0);
        chk("rst instWORD", 64'(instWORD), 64'd0);
        chk("rst instPC", 64'(instPC), 64'd0);
        rst = 0;

        // 1: fill with no consumer
        step(0, 1, 18'o1000, 0, 36'd0);
        nacks = 0;
        run(40, 0, 2, 0);
        chk("t1 reads", 64'(nacks), 64'd4);
        chk("t1 memREQ full", 64'(memREQ), 64'd0);
        chk("t1 head pc", 64'(instPC), 64'o1000);

        // 2: continuous consumer, tagged data
        run(60, 1, 1, 1);

        // 3: flush while a read is outstanding
        drain();
        step(0, 1, 18'o1005, 0, 36'd0);
        wait_req(5);
        chk("t3 addr1005", 64'(memADDR), 64'o1005);
        step(0, 1, 18'o2000, 0, 36'd0);
        step(0, 0, 18'd0, 0, 36'd0);
        step(0, 0, 18'd0, 0, 36'd0);
        step(0, 0, 18'd0, 1, rnd36());
        wait_req(5);
        chk("t3 addr2000", 64'(memADDR), 64'o2000);
        run(10, 1, 1, 0);

        // 4: flush + ack + take together
        drain();
        step(0, 1, 18'o3000, 0, 36'd0);
        wait_req(5);
        step(0, 0, 18'd0, 1, rnd36());
        wait_req(5);
        chk("t4 valid before", 64'(instVALID), 64'd1);
        step(1, 1, 18'o3400, 1, rnd36());
        chk("t4 valid after", 64'(instVALID), 64'd0);
        wait_req(5);
        chk("t4 addr3400", 64'(memADDR), 64'o3400);
        run(12, 2, 1, 0);

        // 5: address wrap
        drain();
        step(0, 1, 18'o777776, 0, 36'd0);
        saw0 = 0;
        run(30, 2, 1, 0);
        chk("t5 wrap", 64'(saw0), 64'd1);

        // 6: clock enable freeze, then async reset mid-request
        drain();
        step(0, 1, 18'o4000, 0, 36'd0);
        wait_req(5);
        step(0, 0, 18'd0, 1, rnd36());
        wait_req(5);
        clken = 0;
        for (int i = 0; i < 4; i++) begin
            step(i[0], i == 2, 18'o7, 1, rnd36());
            chk("t6 frz memREQ", 64'(memREQ), 64'd1);
            chk("t6 frz memADDR", 64'(memADDR), 64'o4001);
            chk("t6 frz instPC", 64'(instPC), 64'o4000);
        end
        clken = 1;
        chk("t6 valid pre-rst", 64'(instVALID), 64'd1);
        rst = 1;
        #1;
        chk("t6 rst memREQ", 64'(memREQ), 64'd0);
        chk("t6 rst instVALID", 64'(instVALID), 64'd0);
        #20 rst = 0;
        run(10, 2, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
